cacheway_l2p: RTL and testbench
===============================

# cacheway_l2p

Parametrised L2 cache way: one way of a set-associative L2, holding data, tag, valid and dirty state for 2^IDX_W sets. Adds per-byte write merging, synchronous reset of all state, and a flush engine. The flush engine walks every set, hands dirty lines to the L2 controller over a valid/ack write-back handshake, and then cleans or invalidates them. The block sits under the L2 controller; one instance per way.

## Interface
- IDX_W, 3: set index width; the way holds SETS = 2^IDX_W sets.
- TAG_W, 24: tag width.
- LINE_W, 256: line width in bits; must be a multiple of 8; BE_W = LINE_W/8.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- index  in  IDX_W  set for lookup, fill and write.
- tag_in  in  TAG_W  tag for compare and fill.
- line_in  in  LINE_W  fill data from memory.
- wdata_in  in  LINE_W  upstream write data, line-aligned.
- wbe_in  in  BE_W  byte enables for wdata_in.
- load_line  in  1  fill: write line_in and tag_in; set valid; clear dirty.
- load_word  in  1  write: merge wdata_in bytes where wbe_in=1; set dirty.
- flush_req  in  1  start flush; sampled only when idle.
- flush_inv  in  1  captured with flush_req: 1 invalidates each line, 0 cleans it (clears dirty, keeps valid).
- wb_ack  in  1  controller has accepted the current write-back.
- hit  out  1  valid[index] and tag[index]==tag_in; forced 0 while busy.
- dirty  out  1  dirty[index].
- tag_out  out  TAG_W  tag[index].
- line_out  out  LINE_W  data[index].
- busy  out  1  flush in progress.
- wb_valid  out  1  a write-back is pending.
- wb_index  out  IDX_W  set of the pending write-back.
- wb_tag  out  TAG_W  tag of the pending write-back.
- wb_line  out  LINE_W  data of the pending write-back.
- flush_done  out  1  one-cycle pulse when a flush completes.

## Operation
- Storage is flop-based. Reads are combinational from index, or from the flush pointer for wb_*. Writes happen at the clock edge.
- Fill and write when not busy:
  - load_line writes data, tag and valid=1, dirty=0.
  - load_word merges bytes (byte b takes wdata_in[8b+7:8b] when wbe_in[b]=1, otherwise keeps the old byte) and sets dirty=1. Valid and tag are unchanged.
  - load_word does not check hit; gating it is the controller's job.
  - load_line and load_word in the same cycle: load_line wins and load_word is dropped.
- Flush FSM, states IDLE, SCAN, WB; ptr is IDX_W bits.
  - IDLE: flush_req=1 → SCAN. ptr←0, mode←flush_inv.
  - SCAN, set ptr valid and dirty: → WB, without modifying the set.
  - SCAN, set ptr not (valid and dirty): if mode=1, valid[ptr]←0. If ptr==SETS-1, → IDLE and pulse flush_done; otherwise ptr←ptr+1.
  - WB: wb_valid=1, with wb_index=ptr and wb_tag/wb_line from set ptr, all held stable until wb_ack.
  - WB with wb_ack=1: dirty[ptr]←0, and valid[ptr]←0 if mode=1. Then advance ptr or finish exactly as in SCAN.
- busy=1 in SCAN and WB. While busy, load_line, load_word and flush_req are ignored and hit=0. dirty, tag_out and line_out keep tracking index.
- wb_ack outside WB is ignored.
- Reset, including mid-flush:
  - All valid and dirty bits clear; FSM → IDLE; ptr=0.
  - busy, wb_valid and flush_done are 0.
  - A pending write-back is abandoned.
  - Data and tag arrays are not reset.

## Timing
- Reset values: hit=0, dirty=0, busy=0, wb_valid=0, flush_done=0, wb_index=0. tag_out, line_out, wb_tag and wb_line are undefined.
- Lookup has zero latency: hit, dirty, tag_out and line_out are combinational from index/tag_in. A fill or write is visible the cycle after the edge.
- busy rises the cycle after the edge that samples flush_req.
- A clean set costs one SCAN cycle. A dirty set costs one SCAN cycle, then WB cycles up to and including the one with wb_ack high.
- Flush of an all-clean way: busy high for SETS cycles; flush_done asserts in the cycle after the last SCAN cycle, coincident with busy falling.
- wb_valid rises the cycle after the SCAN cycle that found a dirty line. It falls the cycle after wb_ack, or after rst.
- wb_ack may be high on the first WB cycle: zero-wait acceptance.

## Test plan
- Reset, then index=5, tag_in=0xABCDEF, load_line with line_in=pattern P → next cycle hit=1, dirty=0, line_out=P; tag_in=0xABCDEE → hit=0.
- Fill set 2, then load_word with wbe_in bits 0–3 set and wdata_in=all 0x11 → line_out bytes 0–3 = 0x11, other bytes = P, dirty=1.
- Same cycle load_line=1 and load_word=1 on set 3 → line_out=line_in, dirty=0.
- Defaults; dirty sets 1 and 6; flush_inv=1; wb_ack delayed 3 cycles each → exactly two write-backs, wb_index 1 then 6, payload stable while waiting. flush_done once. Afterwards every set hit=0, dirty=0.
- flush_inv=0 over an all-clean way → busy for exactly 8 cycles; valid bits unchanged; hit still 1 on filled sets; load_line issued mid-flush is ignored.
- rst asserted while in WB at set 4 → next cycle wb_valid=0, busy=0, no flush_done; every set hit=0, dirty=0.

Source files
------------

// File: rtl/cacheway_l2p.sv
// cacheway_l2p: one way of a set-associative L2 cache.
// Holds data, tag, valid and dirty state per set, merges byte-enabled
// writes, and runs a flush engine that walks every set and hands dirty
// lines to the L2 controller over a valid/ack write-back handshake.
module cacheway_l2p #(
    parameter  int IDX_W  = 3,
    parameter  int TAG_W  = 24,
    parameter  int LINE_W = 256,
    localparam int BE_W   = LINE_W / 8,
    localparam int SETS   = 1 << IDX_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [IDX_W-1:0]  index,
    input  logic [TAG_W-1:0]  tag_in,
    input  logic [LINE_W-1:0] line_in,
    input  logic [LINE_W-1:0] wdata_in,
    input  logic [BE_W-1:0]   wbe_in,
    input  logic              load_line,
    input  logic              load_word,
    input  logic              flush_req,
    input  logic              flush_inv,
    input  logic              wb_ack,
    output logic              hit,
    output logic              dirty,
    output logic [TAG_W-1:0]  tag_out,
    output logic [LINE_W-1:0] line_out,
    output logic              busy,
    output logic              wb_valid,
    output logic [IDX_W-1:0]  wb_index,
    output logic [TAG_W-1:0]  wb_tag,
    output logic [LINE_W-1:0] wb_line,
    output logic              flush_done
);

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        WB
    } state_t;

    // Storage arrays; data and tag are deliberately left without reset.
    logic [LINE_W-1:0] data_q [SETS];
    logic [TAG_W-1:0]  tag_q  [SETS];
    logic [SETS-1:0]   valid_q;
    logic [SETS-1:0]   dirty_q;

    // Flush engine state.
    state_t            state_q, state_d;
    logic [IDX_W-1:0]  ptr_q, ptr_d;
    logic              mode_q, mode_d;
    logic              done_q, done_d;
    logic              clr_valid;
    logic              clr_dirty;
    logic              step_ptr;

    // Upstream access qualifiers: a fill beats a write in the same cycle.
    logic              fill_en;
    logic              write_en;
    logic [LINE_W-1:0] merged_line;

    assign busy     = (state_q != IDLE);
    assign fill_en  = load_line && !busy;
    assign write_en = load_word && !load_line && !busy;

    // Byte-wise merge of upstream write data into the addressed line.
    always_comb begin
        merged_line = data_q[index];
        for (int b = 0; b < BE_W; b++) begin
            if (wbe_in[b]) begin
                merged_line[8*b +: 8] = wdata_in[8*b +: 8];
            end
        end
    end

    // Data and tag array writes from fills and merged writes.
    always_ff @(posedge clk) begin
        if (fill_en) begin
            data_q[index] <= line_in;
            tag_q[index]  <= tag_in;
        end else if (write_en) begin
            data_q[index] <= merged_line;
        end
    end

    // Valid and dirty bits: upstream updates when idle, flush updates at ptr.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            if (fill_en) begin
                valid_q[index] <= 1'b1;
                dirty_q[index] <= 1'b0;
            end else if (write_en) begin
                dirty_q[index] <= 1'b1;
            end
            if (clr_valid) begin
                valid_q[ptr_q] <= 1'b0;
            end
            if (clr_dirty) begin
                dirty_q[ptr_q] <= 1'b0;
            end
        end
    end

    // Flush engine state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            mode_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            mode_q  <= mode_d;
            done_q  <= done_d;
        end
    end

    // Flush engine next-state: scan each set, stall in WB until acked.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        mode_d    = mode_q;
        done_d    = 1'b0;
        clr_valid = 1'b0;
        clr_dirty = 1'b0;
        step_ptr  = 1'b0;
        case (state_q)
            IDLE: begin
                if (flush_req) begin
                    state_d = SCAN;
                    ptr_d   = '0;
                    mode_d  = flush_inv;
                end
            end
            SCAN: begin
                if (valid_q[ptr_q] && dirty_q[ptr_q]) begin
                    state_d = WB;
                end else begin
                    clr_valid = mode_q;
                    step_ptr  = 1'b1;
                end
            end
            WB: begin
                if (wb_ack) begin
                    clr_dirty = 1'b1;
                    clr_valid = mode_q;
                    step_ptr  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (step_ptr) begin
            if (ptr_q == {IDX_W{1'b1}}) begin
                state_d = IDLE;
                done_d  = 1'b1;
            end else begin
                state_d = SCAN;
                ptr_d   = ptr_q + IDX_W'(1);
            end
        end
    end

    assign hit        = !busy && valid_q[index] && (tag_q[index] == tag_in);
    assign dirty      = dirty_q[index];
    assign tag_out    = tag_q[index];
    assign line_out   = data_q[index];
    assign wb_valid   = (state_q == WB);
    assign wb_index   = ptr_q;
    assign wb_tag     = tag_q[ptr_q];
    assign wb_line    = data_q[ptr_q];
    assign flush_done = done_q;

endmodule

// File: tb/tb_cacheway_l2p.sv
// tb_cacheway_l2p: self-checking bench for cacheway_l2p with a set-level
// reference model, directed scenarios and a randomized operation mix.
module tb_cacheway_l2p;

    localparam int IDX_W  = 3;
    localparam int TAG_W  = 24;
    localparam int LINE_W = 256;
    localparam int BE_W   = LINE_W / 8;
    localparam int SETS   = 1 << IDX_W;

    logic              clk;
    logic              rst;
    logic [IDX_W-1:0]  index;
    logic [TAG_W-1:0]  tag_in;
    logic [LINE_W-1:0] line_in;
    logic [LINE_W-1:0] wdata_in;
    logic [BE_W-1:0]   wbe_in;
    logic              load_line;
    logic              load_word;
    logic              flush_req;
    logic              flush_inv;
    logic              wb_ack;
    logic              hit;
    logic              dirty;
    logic [TAG_W-1:0]  tag_out;
    logic [LINE_W-1:0] line_out;
    logic              busy;
    logic              wb_valid;
    logic [IDX_W-1:0]  wb_index;
    logic [TAG_W-1:0]  wb_tag;
    logic [LINE_W-1:0] wb_line;
    logic              flush_done;

    // Reference model: per-set contents as plain arrays.
    bit                m_valid [SETS];
    bit                m_dirty [SETS];
    bit                m_known [SETS];
    logic [TAG_W-1:0]  m_tag   [SETS];
    logic [LINE_W-1:0] m_data  [SETS];

    int vectors;
    int miscompares;

    logic [TAG_W-1:0] tag_pool [4];

    cacheway_l2p #(
        .IDX_W (IDX_W),
        .TAG_W (TAG_W),
        .LINE_W(LINE_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .index     (index),
        .tag_in    (tag_in),
        .line_in   (line_in),
        .wdata_in  (wdata_in),
        .wbe_in    (wbe_in),
        .load_line (load_line),
        .load_word (load_word),
        .flush_req (flush_req),
        .flush_inv (flush_inv),
        .wb_ack    (wb_ack),
        .hit       (hit),
        .dirty     (dirty),
        .tag_out   (tag_out),
        .line_out  (line_out),
        .busy      (busy),
        .wb_valid  (wb_valid),
        .wb_index  (wb_index),
        .wb_tag    (wb_tag),
        .wb_line   (wb_line),
        .flush_done(flush_done)
    );

    // Free-running clock, 10 time units per cycle.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [LINE_W-1:0] got,
                               input logic [LINE_W-1:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    function automatic logic [LINE_W-1:0] randLine();
        logic [LINE_W-1:0] r;
        for (int i = 0; i < LINE_W / 32; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [LINE_W-1:0] mergeBytes(input logic [LINE_W-1:0] old_l,
                                                     input logic [LINE_W-1:0] wd,
                                                     input logic [BE_W-1:0] be);
        logic [7:0]        bytes [BE_W];
        logic [LINE_W-1:0] r;
        for (int b = 0; b < BE_W; b++) bytes[b] = be[b] ? wd[8*b +: 8] : old_l[8*b +: 8];
        r = '0;
        for (int b = BE_W - 1; b >= 0; b--) r = (r << 8) | LINE_W'(bytes[b]);
        return r;
    endfunction

    task automatic modelReset();
        for (int i = 0; i < SETS; i++) begin
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
        end
    endtask

    // Reset with checks of the reset output values while rst is held.
    task automatic doReset();
        load_line = 1'b0;
        load_word = 1'b0;
        flush_req = 1'b0;
        wb_ack    = 1'b0;
        rst       = 1'b1;
        step();
        checkOutput("rst_hit", hit, 0);
        checkOutput("rst_dirty", dirty, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_wb_valid", wb_valid, 0);
        checkOutput("rst_flush_done", flush_done, 0);
        checkOutput("rst_wb_index", wb_index, 0);
        rst = 1'b0;
        modelReset();
    endtask

    // One upstream access cycle while idle, mirrored into the model.
    task automatic applyStimulus(input bit ll, input bit lw, input int idx,
                                 input logic [TAG_W-1:0] tg, input logic [LINE_W-1:0] ln,
                                 input logic [LINE_W-1:0] wd, input logic [BE_W-1:0] be);
        load_line = ll;
        load_word = lw;
        index     = IDX_W'(idx);
        tag_in    = tg;
        line_in   = ln;
        wdata_in  = wd;
        wbe_in    = be;
        step();
        load_line = 1'b0;
        load_word = 1'b0;
        if (ll) begin
            m_data[idx]  = ln;
            m_tag[idx]   = tg;
            m_valid[idx] = 1'b1;
            m_dirty[idx] = 1'b0;
            m_known[idx] = 1'b1;
        end else if (lw) begin
            m_data[idx]  = mergeBytes(m_data[idx], wd, be);
            m_dirty[idx] = 1'b1;
        end
    endtask

    task automatic checkLookup(input int idx, input logic [TAG_W-1:0] tg);
        bit exp_hit;
        index  = IDX_W'(idx);
        tag_in = tg;
        #1;
        exp_hit = m_valid[idx] && (m_tag[idx] == tg);
        checkOutput("hit", hit, exp_hit);
        checkOutput("dirty", dirty, m_dirty[idx]);
        if (m_known[idx]) begin
            checkOutput("line_out", line_out, m_data[idx]);
            checkOutput("tag_out", tag_out, m_tag[idx]);
        end
        step();
    endtask

    task automatic sweep();
        for (int i = 0; i < SETS; i++) begin
            checkLookup(i, m_known[i] ? m_tag[i] : tag_pool[$urandom_range(0, 3)]);
        end
    endtask

    // Flush with per-write-back ack delays; checks order, payload, timing.
    task automatic runFlush(input bit inv, input int max_delay, input int fixed_delay,
                            input bit inject, input int inj_idx);
        int q[$];
        int delays[$];
        int expected_cycles;
        int cycles;
        int wb_n;
        int waitc;
        bit ack;
        expected_cycles = SETS;
        for (int i = 0; i < SETS; i++) begin
            if (m_valid[i] && m_dirty[i]) begin
                int d;
                d = (fixed_delay >= 0) ? fixed_delay : $urandom_range(0, max_delay);
                q.push_back(i);
                delays.push_back(d);
                expected_cycles += d + 1;
            end
        end
        flush_req = 1'b1;
        flush_inv = inv;
        index     = IDX_W'(inj_idx);
        tag_in    = m_tag[inj_idx];
        step();
        flush_req = 1'b0;
        flush_inv = 1'($urandom);
        cycles = 0;
        wb_n   = 0;
        waitc  = 0;
        while (busy === 1'b1 && cycles < 300) begin
            checkOutput("flush_done_busy", flush_done, 0);
            checkOutput("hit_busy", hit, 0);
            ack = 1'b0;
            if (wb_valid === 1'b1) begin
                if (wb_n < q.size()) begin
                    checkOutput("wb_index", wb_index, q[wb_n]);
                    checkOutput("wb_tag", wb_tag, m_tag[q[wb_n]]);
                    checkOutput("wb_line", wb_line, m_data[q[wb_n]]);
                    if (waitc == delays[wb_n]) ack = 1'b1;
                    else waitc++;
                end else begin
                    checkOutput("wb_extra", wb_n, q.size());
                    ack = 1'b1;
                end
                wb_ack = ack;
            end else begin
                wb_ack = 1'($urandom);
            end
            if (inject && cycles == 2) begin
                load_line = 1'b1;
                line_in   = randLine();
                tag_in    = m_tag[inj_idx] ^ 24'h000F0F;
            end
            step();
            load_line = 1'b0;
            tag_in    = m_tag[inj_idx];
            if (ack) begin
                wb_n++;
                waitc = 0;
            end
            cycles++;
        end
        wb_ack = 1'b0;
        checkOutput("flush_cycles", cycles, expected_cycles);
        checkOutput("wb_count", wb_n, q.size());
        checkOutput("flush_done", flush_done, 1);
        checkOutput("busy_fall", busy, 0);
        step();
        checkOutput("flush_done_once", flush_done, 0);
        for (int i = 0; i < SETS; i++) begin
            if (m_valid[i] && m_dirty[i]) m_dirty[i] = 1'b0;
            if (inv) m_valid[i] = 1'b0;
        end
    endtask

    initial begin
        logic [LINE_W-1:0] pat;
        bit found;
        vectors     = 0;
        miscompares = 0;
        tag_pool[0] = 24'hABCDEF;
        tag_pool[1] = 24'h123456;
        tag_pool[2] = 24'hABCDEE;
        tag_pool[3] = 24'h00F00D;
        rst       = 1'b1;
        index     = '0;
        tag_in    = '0;
        line_in   = '0;
        wdata_in  = '0;
        wbe_in    = '0;
        load_line = 1'b0;
        load_word = 1'b0;
        flush_req = 1'b0;
        flush_inv = 1'b0;
        wb_ack    = 1'b0;
        for (int i = 0; i < SETS; i++) m_known[i] = 1'b0;
        pat = {4{64'h0F1E_2D3C_4B5A_6978}};
        step();
        doReset();

        // Fill and tag compare.
        applyStimulus(1, 0, 5, 24'hABCDEF, pat, '0, '0);
        checkLookup(5, 24'hABCDEF);
        checkLookup(5, 24'hABCDEE);

        // Byte-merge write.
        applyStimulus(1, 0, 2, 24'h123456, pat, '0, '0);
        applyStimulus(0, 1, 2, 24'h123456, '0, {32{8'h11}}, 32'h0000_000F);
        checkLookup(2, 24'h123456);

        // Fill and write together: fill wins.
        applyStimulus(1, 1, 3, 24'h00F00D, randLine(), randLine(), '1);
        checkLookup(3, 24'h00F00D);

        // Invalidating flush with dirty sets 1 and 6, ack after 3 cycles.
        doReset();
        for (int i = 0; i < SETS; i++) applyStimulus(1, 0, i, tag_pool[i % 4], randLine(), '0, '0);
        applyStimulus(0, 1, 1, '0, '0, randLine(), 32'hF0F0_1234);
        applyStimulus(0, 1, 6, '0, '0, randLine(), 32'hFFFF_FFFF);
        runFlush(1, 0, 3, 0, 0);
        sweep();

        // Cleaning flush over an all-clean way with a blocked mid-flush fill.
        for (int i = 0; i < SETS; i++) applyStimulus(1, 0, i, tag_pool[(i + 1) % 4], randLine(), '0, '0);
        runFlush(0, 0, 0, 1, 3);
        sweep();

        // Reset while a write-back of set 4 is pending.
        applyStimulus(0, 1, 4, '0, '0, randLine(), 32'h0000_FFFF);
        flush_req = 1'b1;
        flush_inv = 1'b1;
        step();
        flush_req = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 40 && !found; c++) begin
            if (wb_valid === 1'b1 && wb_index == 3'd4) found = 1'b1;
            else step();
        end
        checkOutput("reach_wb4", found, 1);
        rst = 1'b1;
        step();
        checkOutput("rst_wb_valid_mid", wb_valid, 0);
        checkOutput("rst_busy_mid", busy, 0);
        checkOutput("rst_done_mid", flush_done, 0);
        rst = 1'b0;
        modelReset();
        step();
        checkOutput("post_rst_done", flush_done, 0);
        sweep();

        // Randomized operation mix against the model.
        for (int n = 0; n < 150; n++) begin
            int op;
            int idx;
            op  = $urandom_range(0, 9);
            idx = $urandom_range(0, SETS - 1);
            if (op <= 3) begin
                applyStimulus(1, 0, idx, tag_pool[$urandom_range(0, 3)], randLine(), '0, '0);
            end else if (op <= 6) begin
                applyStimulus(0, 1, idx, '0, '0, randLine(), BE_W'($urandom));
            end else if (op == 7) begin
                applyStimulus(1, 1, idx, tag_pool[$urandom_range(0, 3)], randLine(), randLine(),
                              BE_W'($urandom));
            end else if (op == 9) begin
                runFlush(1'($urandom), 3, -1, 1'($urandom), idx);
            end
            idx = $urandom_range(0, SETS - 1);
            checkLookup(idx, ($urandom_range(0, 1) == 1 && m_known[idx]) ? m_tag[idx]
                                                                      : tag_pool[$urandom_range(0, 3)]);
        end
        sweep();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
